// File: rtl/score_keeper.sv
// BCD score accumulator: awards queue into a saturating pending counter and
// drain into the score one point per clock; tracks bonus intervals and high score.
module score_keeper #(
  parameter int DIGITS         = 4,
  parameter int ADD_WIDTH      = 4,
  parameter int PEND_WIDTH     = 6,
  parameter int BONUS_INTERVAL = 500
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  add_valid_i,
  input  logic [ADD_WIDTH-1:0]  add_points_i,
  input  logic                  commit_i,
  output logic [4*DIGITS-1:0]   score_bcd_o,
  output logic [4*DIGITS-1:0]   high_bcd_o,
  output logic                  busy_o,
  output logic                  saturated_o,
  output logic                  bonus_o,
  output logic                  new_high_o
);

  localparam int SW  = 4 * DIGITS;
  localparam int PW1 = PEND_WIDTH + 1;
  localparam int BW  = (BONUS_INTERVAL > 1) ? $clog2(BONUS_INTERVAL) : 1;
  localparam logic [PEND_WIDTH:0] PEND_MAX   = {1'b0, {PEND_WIDTH{1'b1}}};
  localparam logic [BW-1:0]       BONUS_LAST = (BONUS_INTERVAL > 0) ? BW'(BONUS_INTERVAL - 1) : '0;

  logic [SW-1:0]         score_q, score_d;
  logic [SW-1:0]         high_q, high_d;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  defer_q, defer_d;
  logic                  bonus_q, bonus_d;
  logic                  new_high_q, new_high_d;

  logic [SW-1:0]         score_inc;
  logic [DIGITS-1:0]     dig_nine;
  logic [DIGITS-1:0]     carry;
  logic [PEND_WIDTH:0]   pend_sum;
  logic                  sat;
  logic                  drain;
  logic                  cmp;

  // Ripple +1 across the BCD digits; digit i increments only when all lower digits are 9.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [3:0] dig;
    assign dig         = score_q[4*g +: 4];
    assign dig_nine[g] = (dig == 4'd9);
    if (g == 0) begin : g_c0
      assign carry[g] = 1'b1;
    end else begin : g_cn
      assign carry[g] = carry[g-1] & dig_nine[g-1];
    end
    assign score_inc[4*g +: 4] = carry[g] ? (dig_nine[g] ? 4'd0 : 4'(dig + 4'd1)) : dig;
  end

  assign sat   = &dig_nine;
  assign drain = (pend_q != '0) && !sat;

  // One extra bit of headroom so the award sum can be clamped instead of wrapping.
  assign pend_sum = {1'b0, pend_q}
                  + (add_valid_i ? PW1'(add_points_i) : '0)
                  - {{PEND_WIDTH{1'b0}}, drain};

  // Compare only once nothing is left to drain, so the final score is what gets ranked.
  assign cmp = (commit_i || defer_q) && (pend_q == '0);

  always_comb begin
    score_d    = score_q;
    high_d     = high_q;
    pend_d     = pend_q;
    bcnt_d     = bcnt_q;
    defer_d    = defer_q;
    bonus_d    = 1'b0;
    new_high_d = 1'b0;
    if (clear_i) begin
      score_d = '0;
      pend_d  = '0;
      bcnt_d  = '0;
      defer_d = 1'b0;
    end else begin
      if (sat) begin
        pend_d = '0;
      end else if (pend_sum > PEND_MAX) begin
        pend_d = PEND_MAX[PEND_WIDTH-1:0];
      end else begin
        pend_d = pend_sum[PEND_WIDTH-1:0];
      end

      if (drain) begin
        score_d = score_inc;
        if (BONUS_INTERVAL > 0) begin
          if (bcnt_q == BONUS_LAST) begin
            bcnt_d  = '0;
            bonus_d = 1'b1;
          end else begin
            bcnt_d = BW'(bcnt_q + 1'b1);
          end
        end
      end

      // Packed BCD with the MSD on top orders the same as a plain unsigned compare.
      if (cmp) begin
        defer_d = 1'b0;
        if (score_q > high_q) begin
          high_d     = score_q;
          new_high_d = 1'b1;
        end
      end else if (commit_i) begin
        defer_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      score_q    <= '0;
      high_q     <= '0;
      pend_q     <= '0;
      bcnt_q     <= '0;
      defer_q    <= 1'b0;
      bonus_q    <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      score_q    <= score_d;
      high_q     <= high_d;
      pend_q     <= pend_d;
      bcnt_q     <= bcnt_d;
      defer_q    <= defer_d;
      bonus_q    <= bonus_d;
      new_high_q <= new_high_d;
    end
  end

  assign score_bcd_o = score_q;
  assign high_bcd_o  = high_q;
  assign busy_o      = (pend_q != '0) || defer_q;
  assign saturated_o = sat;
  assign bonus_o     = bonus_q;
  assign new_high_o  = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: default instance plus a PEND_WIDTH=4 instance
// for the pending-cap case.
module tb_score_keeper;
  logic        clk = 1'b0;
  logic        rst, clr, av, cm;
  logic [3:0]  ap;
  logic [15:0] score, high;
  logic        busy, sat, bonus, nh;

  logic        p_av;
  logic [3:0]  p_ap;
  logic [15:0] p_score, p_high;
  logic        p_busy, p_sat, p_bonus, p_nh;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  score_keeper #(.DIGITS(4), .ADD_WIDTH(4), .PEND_WIDTH(6), .BONUS_INTERVAL(500)) dut (
    .clk_i(clk), .reset_i(rst), .clear_i(clr), .add_valid_i(av), .add_points_i(ap),
    .commit_i(cm), .score_bcd_o(score), .high_bcd_o(high), .busy_o(busy),
    .saturated_o(sat), .bonus_o(bonus), .new_high_o(nh));

  score_keeper #(.DIGITS(4), .ADD_WIDTH(4), .PEND_WIDTH(4), .BONUS_INTERVAL(500)) dut_p4 (
    .clk_i(clk), .reset_i(rst), .clear_i(1'b0), .add_valid_i(p_av), .add_points_i(p_ap),
    .commit_i(1'b0), .score_bcd_o(p_score), .high_bcd_o(p_high), .busy_o(p_busy),
    .saturated_o(p_sat), .bonus_o(p_bonus), .new_high_o(p_nh));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic award(input int v);
    av = 1'b1;
    ap = 4'(v);
    tick();
    av = 1'b0;
    ap = 4'd0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 200) begin
      tick();
      i++;
    end
    if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic bring(input int n);
    int v;
    while (n > 0) begin
      v = (n > 15) ? 15 : n;
      award(v);
      wait_idle();
      n -= v;
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int nb, nn, i;
    logic [15:0] sc_at;
    rst = 1'b1; clr = 1'b0; av = 1'b0; ap = 4'd0; cm = 1'b0;
    p_av = 1'b0; p_ap = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst_score", {16'd0, score}, 32'h0);
    chk("rst_high",  {16'd0, high},  32'h0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_sat",   {31'd0, sat},   32'd0);
    chk("rst_bonus", {31'd0, bonus}, 32'd0);
    chk("rst_nh",    {31'd0, nh},    32'd0);

    // award 5: score steps 1..5 on the five edges after the award edge
    award(5);
    chk("t1_score0", {16'd0, score}, 32'h0);
    chk("t1_busy0",  {31'd0, busy},  32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t1_score", {16'd0, score}, 32'(k));
      chk("t1_busy",  {31'd0, busy},  (k < 5) ? 32'd1 : 32'd0);
    end

    do_clear();
    chk("clr_score", {16'd0, score}, 32'h0);

    // carry ripple through two digits
    bring(98);
    chk("t2_start", {16'd0, score}, 32'h0098);
    award(3);
    tick(); chk("t2_0099", {16'd0, score}, 32'h0099);
    tick(); chk("t2_0100", {16'd0, score}, 32'h0100);
    tick(); chk("t2_0101", {16'd0, score}, 32'h0101);

    // bonus fires once as 0500 is reached
    do_clear();
    bring(495);
    chk("t5_start", {16'd0, score}, 32'h0495);
    award(10);
    nb = 0; sc_at = '0;
    for (int k = 0; k < 14; k++) begin
      if (bonus) begin nb++; sc_at = score; end
      tick();
    end
    chk("t5_nbonus", 32'(nb), 32'd1);
    chk("t5_at",     {16'd0, sc_at}, 32'h0500);
    chk("t5_end",    {16'd0, score}, 32'h0505);

    // first high score 0120
    do_clear();
    bring(120);
    cm = 1'b1; tick(); cm = 1'b0;
    chk("t6_nh1",   {31'd0, nh},   32'd1);
    chk("t6_high1", {16'd0, high}, 32'h0120);
    tick();
    chk("t6_nh1off", {31'd0, nh}, 32'd0);

    // deferred commit while 10 points still pending
    do_clear();
    chk("t6_highkept", {16'd0, high}, 32'h0120);
    bring(115);
    award(10);
    cm = 1'b1; tick();
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_nodefnh", {31'd0, nh}, 32'd0);
    tick(); cm = 1'b0;
    nn = 0; i = 0;
    while (busy && i < 40) begin
      if (nh) nn++;
      tick();
      i++;
    end
    if (busy) chk("t6_timeout", {31'd0, busy}, 32'd0);
    if (nh) nn++;
    tick();
    if (nh) nn++;
    chk("t6_nhcount", 32'(nn), 32'd1);
    chk("t6_high2",   {16'd0, high}, 32'h0125);
    chk("t6_score2",  {16'd0, score}, 32'h0125);

    // commit with lower score: nothing happens
    do_clear();
    cm = 1'b1; tick(); cm = 1'b0;
    chk("t6_nh_low", {31'd0, nh}, 32'd0);
    tick();
    chk("t6_nh_low2", {31'd0, nh}, 32'd0);
    chk("t6_high3",   {16'd0, high}, 32'h0125);

    // saturation at 9999
    do_clear();
    bring(9997);
    chk("t4_start", {16'd0, score}, 32'h9997);
    chk("t4_sat0",  {31'd0, sat},   32'd0);
    award(9);
    nb = 0; i = 0;
    while (busy && i < 40) begin
      tick();
      if (bonus) nb++;
      i++;
    end
    chk("t4_score", {16'd0, score}, 32'h9999);
    chk("t4_sat",   {31'd0, sat},   32'd1);
    chk("t4_busy",  {31'd0, busy},  32'd0);
    chk("t4_nobonus", 32'(nb), 32'd0);
    award(5);
    chk("t4_discard_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    chk("t4_nowrap", {16'd0, score}, 32'h9999);

    // pending cap with PEND_WIDTH=4: 1 + 15 points reach the score, not 30
    p_av = 1'b1; p_ap = 4'd15; tick();
    tick();
    p_av = 1'b0; p_ap = 4'd0;
    i = 0;
    while (p_busy && i < 60) begin
      tick();
      i++;
    end
    chk("t3_busy",  {31'd0, p_busy},  32'd0);
    chk("t3_score", {16'd0, p_score}, 32'h0016);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
